// File: rtl/fuzzy_cut_sched.sv
// fuzzy_cut_sched: two-requester round-robin scheduler feeding a fuzzy cut-line
// merge unit. Each requester owns a cut_line register; the merged word of the
// granted request is registered onto a valid/ready result channel.
// Optional build macro: FUZZY_CUT_SCHED_STATS_EN adds per-requester 16-bit
// saturating acceptance counters (cnt_a, cnt_b).

module fuzzy_cut_sched #(
    parameter int LongBits_limit = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      a_valid,
    output logic                      a_ready,
    input  logic [LongBits_limit-1:0] a_x,
    input  logic [LongBits_limit-1:0] a_y,
    input  logic                      b_valid,
    output logic                      b_ready,
    input  logic [LongBits_limit-1:0] b_x,
    input  logic [LongBits_limit-1:0] b_y,
    input  logic                      cfg_we,
    input  logic                      cfg_sel,
    input  logic [LongBits_limit-1:0] cfg_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LongBits_limit-1:0] out_z,
    output logic                      out_src
`ifdef FUZZY_CUT_SCHED_STATS_EN
    ,
    output logic [15:0]               cnt_a,
    output logic [15:0]               cnt_b
`endif
);

    localparam int W = LongBits_limit;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Fuzzy merge: set cut bits OR the operands; clear cut bits keep the
    // smaller operand's bit and add a carry-like term when the larger operand
    // has a run of three ones around bit i and the smaller has bit i-1 set.
    // The padded copies make bit -1 and bit W read as zero.
    function automatic logic [W-1:0] fuzzy_merge(
        input logic [W-1:0] x,
        input logic [W-1:0] y,
        input logic [W-1:0] cut
    );
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic [W+1:0] lo_e;
        logic [W+1:0] hi_e;
        logic [W-1:0] z;
        if (x < y) begin
            lo = x;
            hi = y;
        end else begin
            lo = y;
            hi = x;
        end
        lo_e = {1'b0, lo, 1'b0};
        hi_e = {1'b0, hi, 1'b0};
        z    = '0;
        for (int i = 0; i < W; i++) begin
            if (cut[i]) begin
                z[i] = x[i] | y[i];
            end else begin
                z[i] = lo[i] | (hi_e[i+2] & hi_e[i+1] & hi_e[i] & lo_e[i]);
            end
        end
        return z;
    endfunction

    state_t         state_r;
    state_t         state_nxt_s;
    logic [W-1:0]   cut_a_r;
    logic [W-1:0]   cut_b_r;
    logic           last_b_r;
    logic [W-1:0]   out_z_r;
    logic           out_src_r;

    logic           grant_b_s;
    logic           accept_ok_s;
    logic           a_ready_s;
    logic           b_ready_s;
    logic           accept_s;
    logic [W-1:0]   sel_x_s;
    logic [W-1:0]   sel_y_s;
    logic [W-1:0]   sel_cut_s;
    logic [W-1:0]   merge_z_s;

    // Round-robin grant and ready generation; ready only while accepting is legal.
    always_comb begin
        grant_b_s   = 1'b0;
        accept_ok_s = 1'b0;
        a_ready_s   = 1'b0;
        b_ready_s   = 1'b0;
        if (a_valid && b_valid) begin
            grant_b_s = ~last_b_r;
        end else begin
            grant_b_s = b_valid;
        end
        // Readies are held low while reset is asserted, independent of the clock.
        accept_ok_s = rst_n & ((state_r == ST_IDLE) | out_ready);
        a_ready_s   = accept_ok_s & a_valid & ~grant_b_s;
        b_ready_s   = accept_ok_s & b_valid & grant_b_s;
    end

    assign accept_s = a_ready_s | b_ready_s;
    assign a_ready  = a_ready_s;
    assign b_ready  = b_ready_s;

    // Operand and cut-line selection for the granted requester.
    always_comb begin
        sel_x_s   = '0;
        sel_y_s   = '0;
        sel_cut_s = '0;
        if (grant_b_s) begin
            sel_x_s   = b_x;
            sel_y_s   = b_y;
            sel_cut_s = cut_b_r;
        end else begin
            sel_x_s   = a_x;
            sel_y_s   = a_y;
            sel_cut_s = cut_a_r;
        end
    end

    assign merge_z_s = fuzzy_merge(sel_x_s, sel_y_s, sel_cut_s);

    // Next-state logic: an acceptance always lands in HOLD; a drained HOLD returns to IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (accept_s) begin
                    state_nxt_s = ST_HOLD;
                end else if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Result registers load on acceptance and otherwise hold steady.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_z_r   <= '0;
            out_src_r <= 1'b0;
        end else if (accept_s) begin
            out_z_r   <= merge_z_s;
            out_src_r <= grant_b_s;
        end
    end

    // Last-grant pointer; reset to B so that A wins the first contest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_b_r <= 1'b1;
        end else if (accept_s) begin
            last_b_r <= grant_b_s;
        end
    end

    // Cut-line registers; a same-cycle acceptance still sees the pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cut_a_r <= '0;
            cut_b_r <= '0;
        end else if (cfg_we) begin
            if (cfg_sel) begin
                cut_b_r <= cfg_data;
            end else begin
                cut_a_r <= cfg_data;
            end
        end
    end

    assign out_valid = (state_r == ST_HOLD);
    assign out_z     = out_z_r;
    assign out_src   = out_src_r;

`ifdef FUZZY_CUT_SCHED_STATS_EN
    logic [15:0] cnt_a_r;
    logic [15:0] cnt_b_r;

    // Saturating per-requester acceptance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a_r <= 16'h0000;
            cnt_b_r <= 16'h0000;
        end else begin
            if (a_ready_s && (cnt_a_r != 16'hFFFF)) begin
                cnt_a_r <= cnt_a_r + 16'h0001;
            end
            if (b_ready_s && (cnt_b_r != 16'hFFFF)) begin
                cnt_b_r <= cnt_b_r + 16'h0001;
            end
        end
    end

    assign cnt_a = cnt_a_r;
    assign cnt_b = cnt_b_r;
`endif

endmodule

// File: tb/tb_fuzzy_cut_sched.sv
// Directed self-checking bench for fuzzy_cut_sched with hand-computed results.
module tb_fuzzy_cut_sched;

    localparam int W = 10;

    logic         clk;
    logic         rst_n;
    logic         a_valid;
    logic         a_ready;
    logic [W-1:0] a_x;
    logic [W-1:0] a_y;
    logic         b_valid;
    logic         b_ready;
    logic [W-1:0] b_x;
    logic [W-1:0] b_y;
    logic         cfg_we;
    logic         cfg_sel;
    logic [W-1:0] cfg_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_z;
    logic         out_src;
`ifdef FUZZY_CUT_SCHED_STATS_EN
    logic [15:0]  cnt_a;
    logic [15:0]  cnt_b;
`endif

    int checks   = 0;
    int failures = 0;

    fuzzy_cut_sched #(.LongBits_limit(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_x       (a_x),
        .a_y       (a_y),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_x       (b_x),
        .b_y       (b_y),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_data  (cfg_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z),
        .out_src   (out_src)
`ifdef FUZZY_CUT_SCHED_STATS_EN
        ,
        .cnt_a     (cnt_a),
        .cnt_b     (cnt_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [W-1:0] z, input logic s);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'(v));
        check_eq({tag, "_z"},     32'(out_z),     32'(z));
        check_eq({tag, "_src"},   32'(out_src),   32'(s));
    endtask

    initial begin
        rst_n = 1'b0; a_valid = 1'b1; a_x = 10'h005; a_y = 10'h00A;
        b_valid = 1'b1; b_x = 10'h001; b_y = 10'h007;
        cfg_we = 1'b0; cfg_sel = 1'b0; cfg_data = 10'h000; out_ready = 1'b1;

        // Reset state, with requests pending to show readies are forced low
        #2;
        check_eq("rst_a_ready", 32'(a_ready), 32'h0);
        check_eq("rst_b_ready", 32'(b_ready), 32'h0);
        step();
        check_out("rst", 1'b0, 10'h000, 1'b0);
        a_valid = 1'b0; b_valid = 1'b0;
        #1 rst_n = 1'b1;

        // Program cut_a = 0x3FF
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_data = 10'h3FF;
        step();
        cfg_we = 1'b0;

        // A: x=5, y=A, cut all ones -> 0x00F
        a_valid = 1'b1; a_x = 10'h005; a_y = 10'h00A; out_ready = 1'b1;
        #1 check_eq("a1_ready", 32'(a_ready), 32'h1);
        step();
        a_valid = 1'b0;
        check_out("a1", 1'b1, 10'h00F, 1'b0);
        step();
        check_eq("a1_drain", 32'(out_valid), 32'h0);

        // B with cut_b=0: (1,7) -> 3, then swapped (7,1) -> 3 passed through
        b_valid = 1'b1; b_x = 10'h001; b_y = 10'h007;
        #1;
        check_eq("b1_ready", 32'(b_ready), 32'h1);
        check_eq("b1_a_ready", 32'(a_ready), 32'h0);
        step();
        check_out("b1", 1'b1, 10'h003, 1'b1);
        b_x = 10'h007; b_y = 10'h001;
        step();
        check_out("b2", 1'b1, 10'h003, 1'b1);
        b_valid = 1'b0;
        step();
        check_eq("b_drain", 32'(out_valid), 32'h0);

        // Both valid for 4 cycles: 0,1,0,1 one per cycle
        a_valid = 1'b1; a_x = 10'h005; a_y = 10'h00A;
        b_valid = 1'b1; b_x = 10'h001; b_y = 10'h007;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i % 2 == 0) check_out("rr", 1'b1, 10'h00F, 1'b0);
            else            check_out("rr", 1'b1, 10'h003, 1'b1);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        step();
        check_eq("rr_drain", 32'(out_valid), 32'h0);

        // Backpressure: result held 3 cycles, then pending B passes through
        a_valid = 1'b1; out_ready = 1'b0;
        step();
        check_out("bp0", 1'b1, 10'h00F, 1'b0);
        a_valid = 1'b0; b_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("bp_a_ready", 32'(a_ready), 32'h0);
            check_eq("bp_b_ready", 32'(b_ready), 32'h0);
            step();
            check_out("bp_hold", 1'b1, 10'h00F, 1'b0);
        end
        out_ready = 1'b1;
        #1 check_eq("bp_b_pass", 32'(b_ready), 32'h1);
        step();
        check_out("bp_pass", 1'b1, 10'h003, 1'b1);
        b_valid = 1'b0;
        step();
        check_eq("bp_drain", 32'(out_valid), 32'h0);

        // Same-cycle cfg write: old cut_a=0 used, then new 0x3FF
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_data = 10'h000;
        step();
        cfg_data = 10'h3FF; a_valid = 1'b1;
        step();
        cfg_we = 1'b0;
        check_out("cfg_old", 1'b1, 10'h005, 1'b0);
        step();
        check_out("cfg_new", 1'b1, 10'h00F, 1'b0);
        a_valid = 1'b0;
        step();

        // Asynchronous reset mid-HOLD discards the held result
        b_valid = 1'b1; out_ready = 1'b0;
        step();
        check_out("pre_rst", 1'b1, 10'h003, 1'b1);
        #2 rst_n = 1'b0;
        a_valid = 1'b1; out_ready = 1'b1;
        #1;
        check_out("async_rst", 1'b0, 10'h000, 1'b0);
        check_eq("async_a_ready", 32'(a_ready), 32'h0);
        check_eq("async_b_ready", 32'(b_ready), 32'h0);
        step();
        #1 rst_n = 1'b1;
        #1;
        check_eq("post_a_ready", 32'(a_ready), 32'h1);
        check_eq("post_b_ready", 32'(b_ready), 32'h0);
        step();
        check_out("post_a", 1'b1, 10'h005, 1'b0);
        step();
        check_out("post_b", 1'b1, 10'h003, 1'b1);
        a_valid = 1'b0; b_valid = 1'b0;
        step();
        check_eq("post_drain", 32'(out_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
